// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: round-robin grant with default master, holding the grant
// across fixed-length bursts and locked sequences.
module ahb_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int MW             = 2,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    input  logic                   HREADY,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [MW-1:0]          HMASTER,
    output logic                   HMASTLOCK
);

    localparam logic [1:0]    TRANS_IDLE = 2'b00;
    localparam logic [1:0]    TRANS_NSEQ = 2'b10;
    localparam logic [1:0]    TRANS_SEQ  = 2'b11;
    localparam logic [MW-1:0] DEF_IDX    = MW'(DEFAULT_MASTER);

    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [MW-1:0]          grant_idx_q, grant_idx_d;
    logic [MW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [3:0]             burst_rem_q, burst_rem_d;
    logic [MW-1:0]          master_q;
    logic                   mastlock_q;
    logic                   hold;
    logic                   found;
    logic [MW-1:0]          winner;

    // Remaining beats of the owner's fixed-length burst, updated on accepted beats.
    always_comb begin
        burst_rem_d = burst_rem_q;
        if (HREADY) begin
            case (HTRANS)
                TRANS_NSEQ: begin
                    case (HBURST)
                        3'b010, 3'b011: burst_rem_d = 4'd3;
                        3'b100, 3'b101: burst_rem_d = 4'd7;
                        3'b110, 3'b111: burst_rem_d = 4'd15;
                        default:        burst_rem_d = 4'd0;
                    endcase
                end
                TRANS_SEQ:  burst_rem_d = (burst_rem_q != 4'd0) ? burst_rem_q - 4'd1 : 4'd0;
                TRANS_IDLE: burst_rem_d = 4'd0;
                default:    burst_rem_d = burst_rem_q;
            endcase
        end
    end

    assign hold = (HLOCK[grant_idx_q] & HBUSREQ[grant_idx_q]) | (burst_rem_d != 4'd0);

    // First requester after the last winner, wrapping back to the last winner itself.
    always_comb begin
        found  = 1'b0;
        winner = DEF_IDX;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            int idx;
            idx = (int'(rr_ptr_q) + k) % NUM_MASTERS;
            if (!found && HBUSREQ[idx]) begin
                found  = 1'b1;
                winner = MW'(idx);
            end
        end
    end

    always_comb begin
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
        if (HREADY && !hold) begin
            if (found) begin
                grant_idx_d = winner;
                rr_ptr_d    = winner;
            end else begin
                grant_idx_d = DEF_IDX;
            end
        end
        grant_d              = '0;
        grant_d[grant_idx_d] = 1'b1;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            grant_q              <= '0;
            grant_q[DEF_IDX]     <= 1'b1;
            grant_idx_q          <= DEF_IDX;
            rr_ptr_q             <= DEF_IDX;
            burst_rem_q          <= 4'd0;
            master_q             <= DEF_IDX;
            mastlock_q           <= 1'b0;
        end else begin
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_rem_q <= burst_rem_d;
            // The address phase follows the grant one accepted transfer later.
            if (HREADY) begin
                master_q   <= grant_idx_q;
                mastlock_q <= HLOCK[grant_idx_q];
            end
        end
    end

    assign HGRANT    = grant_q;
    assign HMASTER   = master_q;
    assign HMASTLOCK = mastlock_q;

endmodule
